// File: rtl/dmem_arbiter_if.sv
`timescale 1ns/1ps
// dmem_arbiter_if: bundles both requester ports and the memory-side signals
// of the data-memory arbiter. The arbiter uses the slave view; the requesters
// plus the memory instance together form the master view.
interface dmem_arbiter_if;
    // requester port 0 (CPU load/store unit)
    logic        req0;
    logic        we0;
    logic        lock0;
    logic [31:0] addr0;
    logic [31:0] wdata0;
    logic        gnt0;
    logic        rvalid0;
    logic [31:0] rdata0;
    logic        err0;

    // requester port 1 (debug / program loader)
    logic        req1;
    logic        we1;
    logic        lock1;
    logic [31:0] addr1;
    logic [31:0] wdata1;
    logic        gnt1;
    logic        rvalid1;
    logic [31:0] rdata1;
    logic        err1;

    // memory side
    logic        mem_we;
    logic        mem_re;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  req0, we0, lock0, addr0, wdata0,
        input  req1, we1, lock1, addr1, wdata1,
        input  mem_rdata,
        output gnt0, rvalid0, rdata0, err0,
        output gnt1, rvalid1, rdata1, err1,
        output mem_we, mem_re, mem_addr, mem_wdata
    );

    modport master (
        output req0, we0, lock0, addr0, wdata0,
        output req1, we1, lock1, addr1, wdata1,
        output mem_rdata,
        input  gnt0, rvalid0, rdata0, err0,
        input  gnt1, rvalid1, rdata1, err1,
        input  mem_we, mem_re, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
// dmem_arbiter: two-port round-robin arbiter in front of a single-cycle data
// memory. Three stages: ACCEPT (combinational grant), ACCESS (command
// register drives the memory), RESP (response register drives the winner).
// Optional feature macro: DMEM_ARB_LOCK_EN enables locked follow-on grants,
// bounded to LOCK_MAX consecutive grants per holder.
module dmem_arbiter #(
    parameter int DEPTH    = 32,
    parameter int LOCK_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,
    dmem_arbiter_if.slave bus
);
    // round-robin pointer: port granted most recently
    logic        last_reg;
    logic        last_next;
    logic        tie_pick1;

    // accept stage
    logic        gnt0_c;
    logic        gnt1_c;
    logic        accept;
    logic        win_port;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;

    // command register (ACCESS stage)
    logic        cmd_valid_reg;
    logic        cmd_port_reg;
    logic        cmd_we_reg;
    logic [31:0] cmd_addr_reg;
    logic [31:0] cmd_wdata_reg;
    logic        cmd_in_range;
    logic        cmd_live;
    logic        mem_re_c;

    // response register (RESP stage)
    logic        rsp_valid_reg;
    logic        rsp_port_reg;
    logic        rsp_err_reg;
    logic [31:0] rsp_rdata_reg;

    logic        rvalid_vec [2];
    logic [31:0] rdata_vec  [2];
    logic        err_vec    [2];

`ifdef DMEM_ARB_LOCK_EN
    logic [2:0]  lock_cnt_reg;
    logic [2:0]  lock_cnt_next;
    logic        lock_port_reg;
    logic        lock_port_next;
    logic        sel_lock;

    assign sel_lock = win_port ? bus.lock1 : bus.lock0;

    // tie-break: a live lock run keeps the holder, an exhausted run hands the tie over
    always_comb begin
        tie_pick1 = ~last_reg;
        if (lock_cnt_reg == 3'(LOCK_MAX)) begin
            tie_pick1 = ~lock_port_reg;
        end else if (lock_cnt_reg != 3'd0) begin
            tie_pick1 = lock_port_reg;
        end
    end

    // count consecutive locked grants to the same port; any break clears the run
    always_comb begin
        lock_cnt_next  = 3'd0;
        lock_port_next = lock_port_reg;
        if (accept && (lock_cnt_reg != 3'(LOCK_MAX)) && sel_lock) begin
            if ((lock_cnt_reg != 3'd0) && (lock_port_reg == win_port)) begin
                lock_cnt_next = lock_cnt_reg + 3'd1;
            end else begin
                lock_cnt_next  = 3'd1;
                lock_port_next = win_port;
            end
        end
    end

    // lock run state register
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_cnt_reg  <= 3'd0;
            lock_port_reg <= 1'b0;
        end else begin
            lock_cnt_reg  <= lock_cnt_next;
            lock_port_reg <= lock_port_next;
        end
    end
`else
    // lock inputs and LOCK_MAX have no effect in the plain round-robin build
    localparam int LOCK_MAX_UNUSED = LOCK_MAX;
    logic lock_unused;
    assign lock_unused = bus.lock0 ^ bus.lock1;
    assign tie_pick1   = ~last_reg;
`endif

    // grant: lone requester wins, a tie goes to the tie-break choice; nothing during reset
    always_comb begin
        gnt0_c = 1'b0;
        gnt1_c = 1'b0;
        if (!reset) begin
            if (bus.req0 && bus.req1) begin
                gnt1_c = tie_pick1;
                gnt0_c = ~tie_pick1;
            end else begin
                gnt0_c = bus.req0;
                gnt1_c = bus.req1;
            end
        end
    end

    assign accept    = gnt0_c | gnt1_c;
    assign win_port  = gnt1_c;
    assign sel_we    = win_port ? bus.we1    : bus.we0;
    assign sel_addr  = win_port ? bus.addr1  : bus.addr0;
    assign sel_wdata = win_port ? bus.wdata1 : bus.wdata0;
    assign last_next = accept ? win_port : last_reg;
    assign bus.gnt0  = gnt0_c;
    assign bus.gnt1  = gnt1_c;

    // capture the winning command; reset drops anything in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            last_reg      <= 1'b1;
            cmd_valid_reg <= 1'b0;
            cmd_port_reg  <= 1'b0;
            cmd_we_reg    <= 1'b0;
            cmd_addr_reg  <= 32'h0;
            cmd_wdata_reg <= 32'h0;
        end else begin
            last_reg      <= last_next;
            cmd_valid_reg <= accept;
            if (accept) begin
                cmd_port_reg  <= win_port;
                cmd_we_reg    <= sel_we;
                cmd_addr_reg  <= sel_addr;
                cmd_wdata_reg <= sel_wdata;
            end
        end
    end

    // ACCESS: only an in-range command touches memory, and never while reset is high
    assign cmd_in_range  = (cmd_addr_reg < 32'(DEPTH));
    assign cmd_live      = ~reset & cmd_valid_reg & cmd_in_range;
    assign mem_re_c      = cmd_live & ~cmd_we_reg;
    assign bus.mem_we    = cmd_live & cmd_we_reg;
    assign bus.mem_re    = mem_re_c;
    assign bus.mem_addr  = cmd_live ? cmd_addr_reg  : 32'h0;
    assign bus.mem_wdata = cmd_live ? cmd_wdata_reg : 32'h0;

    // capture the response at the end of ACCESS
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_valid_reg <= 1'b0;
            rsp_port_reg  <= 1'b0;
            rsp_err_reg   <= 1'b0;
            rsp_rdata_reg <= 32'h0;
        end else begin
            rsp_valid_reg <= cmd_valid_reg;
            rsp_port_reg  <= cmd_port_reg;
            rsp_err_reg   <= cmd_valid_reg & ~cmd_in_range;
            rsp_rdata_reg <= mem_re_c ? bus.mem_rdata : 32'h0;
        end
    end

    // route the response to the issuing port only; the other port stays at zero
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_resp
            assign rvalid_vec[gi] = ~reset & rsp_valid_reg & (rsp_port_reg == 1'(gi));
            assign rdata_vec[gi]  = rvalid_vec[gi] ? rsp_rdata_reg : 32'h0;
            assign err_vec[gi]    = rvalid_vec[gi] & rsp_err_reg;
        end
    endgenerate

    assign bus.rvalid0 = rvalid_vec[0];
    assign bus.rvalid1 = rvalid_vec[1];
    assign bus.rdata0  = rdata_vec[0];
    assign bus.rdata1  = rdata_vec[1];
    assign bus.err0    = err_vec[0];
    assign bus.err1    = err_vec[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
// tb_dmem_arbiter: directed plus random stimulus for dmem_arbiter. A
// transaction-level model predicts grants, memory-side activity and
// responses; responses are queued and checked by an independent monitor.
module tb_dmem_arbiter;
    localparam int DEPTH    = 32;
    localparam int LOCK_MAX = 4;

    logic clk    = 1'b0;
    logic reset  = 1'b1;
    int   cyc    = 0;
    int   errors = 0;
    int   checks = 0;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.DEPTH(DEPTH), .LOCK_MAX(LOCK_MAX)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // the data memory: async read, sync write, writes to address 0 dropped
    logic [31:0] mem [DEPTH] = '{default: 32'h0};
    assign bus.mem_rdata = mem[bus.mem_addr[4:0]];
    always @(posedge clk) begin
        if (bus.mem_we && (bus.mem_addr != 32'h0)) mem[bus.mem_addr[4:0]] <= bus.mem_wdata;
    end

    // requester drive
    logic        p_req   [2];
    logic        p_we    [2];
    logic        p_lock  [2];
    logic [31:0] p_addr  [2];
    logic [31:0] p_wdata [2];
    assign bus.req0   = p_req[0];
    assign bus.we0    = p_we[0];
    assign bus.lock0  = p_lock[0];
    assign bus.addr0  = p_addr[0];
    assign bus.wdata0 = p_wdata[0];
    assign bus.req1   = p_req[1];
    assign bus.we1    = p_we[1];
    assign bus.lock1  = p_lock[1];
    assign bus.addr1  = p_addr[1];
    assign bus.wdata1 = p_wdata[1];

    // reference model state
    logic [31:0] ref_mem [DEPTH];
    int          ref_last;
`ifdef DMEM_ARB_LOCK_EN
    int          run;
    int          owner;
`endif
    logic        pend_wr;
    logic [31:0] pend_addr;
    logic [31:0] pend_data;
    logic        prev_valid;
    logic        prev_we;
    logic [31:0] prev_addr;
    logic [31:0] prev_wdata;
    logic        granted [2];
    logic        renew;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;
    exp_t sb_q[$];

    function automatic int model_winner();
        if (p_req[0] && p_req[1]) begin
`ifdef DMEM_ARB_LOCK_EN
            if (run > 0 && run < LOCK_MAX) return owner;
`endif
            return 1 - ref_last;
        end
        if (p_req[0]) return 0;
        if (p_req[1]) return 1;
        return -1;
    endfunction

    // one clock of stimulus: check memory side and grant, predict the response
    task automatic cycle_check();
        int          w;
        exp_t        e;
        logic [1:0]  eg;
        logic        in_rng;
        logic        x_we, x_re;
        logic [31:0] x_addr, x_wdata;
        @(negedge clk);
        if (pend_wr && pend_addr != 32'h0) ref_mem[pend_addr[4:0]] = pend_data;
        pend_wr = 1'b0;

        in_rng  = prev_valid && (prev_addr < DEPTH);
        x_we    = in_rng && prev_we;
        x_re    = in_rng && !prev_we;
        x_addr  = in_rng ? prev_addr : 32'h0;
        x_wdata = in_rng ? prev_wdata : 32'h0;
        checks++;
        if (bus.mem_we !== x_we || bus.mem_re !== x_re || bus.mem_addr !== x_addr || bus.mem_wdata !== x_wdata) begin
            errors++;
            $display("FAIL access cyc=%0d got we=%b re=%b addr=%h wdata=%h; exp we=%b re=%b addr=%h wdata=%h",
                     cyc, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata, x_we, x_re, x_addr, x_wdata);
        end

        w  = model_winner();
        eg = (w == 0) ? 2'b01 : (w == 1) ? 2'b10 : 2'b00;
        checks++;
        if ({bus.gnt1, bus.gnt0} !== eg) begin
            errors++;
            $display("FAIL grant cyc=%0d got gnt1,gnt0=%b exp=%b", cyc, {bus.gnt1, bus.gnt0}, eg);
        end

`ifdef DMEM_ARB_LOCK_EN
        if (w < 0 || run == LOCK_MAX) run = 0;
        else if (p_lock[w]) begin
            if (run != 0 && owner == w) run++;
            else begin
                run   = 1;
                owner = w;
            end
        end else run = 0;
`endif

        if (w >= 0) begin
            ref_last = w;
            e.port   = w;
            e.due    = cyc + 2;
            e.err    = 1'b0;
            e.rdata  = 32'h0;
            if (p_addr[w] >= DEPTH) e.err = 1'b1;
            else if (p_we[w]) begin
                pend_wr   = 1'b1;
                pend_addr = p_addr[w];
                pend_data = p_wdata[w];
            end else e.rdata = ref_mem[p_addr[w][4:0]];
            sb_q.push_back(e);
            $display("accept cyc=%0d port=%0d we=%b addr=%h wdata=%h -> rdata=%h err=%b",
                     cyc, w, p_we[w], p_addr[w], p_wdata[w], e.rdata, e.err);
            granted[w] = 1'b1;
            prev_valid = 1'b1;
            prev_we    = p_we[w];
            prev_addr  = p_addr[w];
            prev_wdata = p_wdata[w];
        end else prev_valid = 1'b0;

        @(posedge clk);
        #1;
        if (w >= 0 && !renew) p_req[w] = 1'b0;
    endtask

    task automatic do_reset(int n);
        reset      = 1'b1;
        sb_q.delete();
        pend_wr    = 1'b0;
        prev_valid = 1'b0;
        repeat (n) begin
            @(negedge clk);
            checks++;
            if (bus.gnt0 || bus.gnt1 || bus.mem_we || bus.mem_re || bus.mem_addr != 32'h0 ||
                bus.mem_wdata != 32'h0 || bus.rvalid0 || bus.rvalid1) begin
                errors++;
                $display("FAIL reset_state cyc=%0d got gnt=%b%b mem_we=%b mem_re=%b addr=%h wdata=%h rvalid=%b%b; exp all 0",
                         cyc, bus.gnt1, bus.gnt0, bus.mem_we, bus.mem_re, bus.mem_addr, bus.mem_wdata,
                         bus.rvalid1, bus.rvalid0);
            end
            @(posedge clk);
            #1;
        end
        reset    = 1'b0;
        ref_last = 1;
`ifdef DMEM_ARB_LOCK_EN
        run      = 0;
`endif
    endtask

    task automatic send(int p, logic w, logic [31:0] a, logic [31:0] d);
        p_req[p]   = 1'b1;
        p_we[p]    = w;
        p_addr[p]  = a;
        p_wdata[p] = d;
        p_lock[p]  = 1'b0;
        granted[p] = 1'b0;
        for (int i = 0; i < 16 && !granted[p]; i++) cycle_check();
        if (!granted[p]) begin
            checks++;
            errors++;
            $display("FAIL send_timeout port=%0d got no grant in 16 cycles exp grant", p);
            p_req[p] = 1'b0;
        end
    endtask

    task automatic hold_both(logic lk0, int n);
        p_req[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 32'd1; p_wdata[0] = 32'h0; p_lock[0] = lk0;
        p_req[1] = 1'b1; p_we[1] = 1'b0; p_addr[1] = 32'd2; p_wdata[1] = 32'h0; p_lock[1] = 1'b0;
        renew = 1'b1;
        repeat (n) cycle_check();
        renew    = 1'b0;
        p_req[0] = 1'b0;
        p_req[1] = 1'b0;
        p_lock[0] = 1'b0;
    endtask

    task automatic new_req(int p);
        int r;
        r          = $urandom_range(0, 99);
        p_req[p]   = 1'b1;
        p_we[p]    = 1'($urandom_range(0, 1));
        p_lock[p]  = 1'($urandom_range(0, 1));
        p_wdata[p] = $urandom;
        if (r < 50)      p_addr[p] = 32'($urandom_range(0, 7));
        else if (r < 85) p_addr[p] = 32'($urandom_range(0, DEPTH - 1));
        else if (r < 95) p_addr[p] = 32'($urandom_range(DEPTH, 100));
        else             p_addr[p] = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
    endtask

    // response monitor: compares every rvalid against the oldest prediction
    always @(negedge clk) begin : monitor
        exp_t        e;
        logic [1:0]  rv;
        logic [1:0]  erv;
        logic [31:0] rd, ord;
        logic        er, oer;
        rv = {bus.rvalid1, bus.rvalid0};
        if (!reset) begin
            if (rv != 2'b00) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL resp_unexpected cyc=%0d got rvalid=%b exp none", cyc, rv);
                end else begin
                    e   = sb_q.pop_front();
                    erv = (e.port == 1) ? 2'b10 : 2'b01;
                    rd  = (e.port == 1) ? bus.rdata1 : bus.rdata0;
                    er  = (e.port == 1) ? bus.err1   : bus.err0;
                    ord = (e.port == 1) ? bus.rdata0 : bus.rdata1;
                    oer = (e.port == 1) ? bus.err0   : bus.err1;
                    if (rv !== erv || rd !== e.rdata || er !== e.err || ord != 32'h0 || oer != 1'b0 || cyc != e.due) begin
                        errors++;
                        $display("FAIL resp cyc=%0d got rvalid=%b rdata=%h err=%b other=%h/%b; exp rvalid=%b rdata=%h err=%b at cyc=%0d",
                                 cyc, rv, rd, er, ord, oer, erv, e.rdata, e.err, e.due);
                    end else begin
                        $display("resp   cyc=%0d port=%0d rdata=%h err=%b ok", cyc, e.port, rd, er);
                    end
                end
            end else begin
                if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                    checks++;
                    errors++;
                    e = sb_q.pop_front();
                    $display("FAIL resp_missing cyc=%0d got no rvalid exp port=%0d rdata=%h err=%b",
                             cyc, e.port, e.rdata, e.err);
                end
                checks++;
                if (bus.rdata0 != 32'h0 || bus.rdata1 != 32'h0 || bus.err0 || bus.err1) begin
                    errors++;
                    $display("FAIL idle_outputs cyc=%0d got rdata=%h/%h err=%b/%b exp zeros",
                             cyc, bus.rdata0, bus.rdata1, bus.err0, bus.err1);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog cyc=%0d got no finish exp finish", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        for (int p = 0; p < 2; p++) begin
            p_req[p] = 1'b0; p_we[p] = 1'b0; p_lock[p] = 1'b0;
            p_addr[p] = 32'h0; p_wdata[p] = 32'h0; granted[p] = 1'b0;
        end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
        ref_last   = 1;
`ifdef DMEM_ARB_LOCK_EN
        run        = 0;
        owner      = 0;
`endif
        pend_wr    = 1'b0;
        pend_addr  = 32'h0;
        pend_data  = 32'h0;
        prev_valid = 1'b0;
        prev_we    = 1'b0;
        prev_addr  = 32'h0;
        prev_wdata = 32'h0;
        renew      = 1'b0;

        // reset state, then write/read back on port 0
        do_reset(2);
        send(0, 1'b1, 32'd5, 32'hDEAD_BEEF);
        send(0, 1'b0, 32'd5, 32'h0);

        // both ports hammering: alternation from port 0 after reset
        do_reset(1);
        hold_both(1'b0, 8);

        // out-of-range read on port 1, then address-0 write/read
        send(1, 1'b0, 32'd40, 32'h0);
        send(0, 1'b1, 32'd0, 32'h0000_1234);
        send(0, 1'b0, 32'd0, 32'h0);

        // reset during the ACCESS cycle of a write discards it
        send(0, 1'b1, 32'd7, 32'hA5A5_0007);
        do_reset(1);
        send(1, 1'b0, 32'd7, 32'h0);

        // port 0 requesting lock against a busy port 1
        do_reset(1);
        hold_both(1'b1, 12);

        // random traffic with withdrawals and occasional resets
        for (int c = 0; c < 600; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!p_req[p]) begin
                    if ($urandom_range(0, 99) < 60) new_req(p);
                end else if ($urandom_range(0, 99) < 4) begin
                    p_req[p] = 1'b0;
                end
            end
            if ($urandom_range(0, 199) == 0) do_reset(1);
            else cycle_check();
        end

        // drain
        p_req[0] = 1'b0;
        p_req[1] = 1'b0;
        repeat (4) cycle_check();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d outstanding responses exp 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
